vis_bank_reader: RTL and testbench

//  Reader side of the correlator's visibilities SRAM. The correlator writes

---
 rtl/tart_pkg.sv | 19 +
 rtl/vis_row_mux.sv | 39 +++
 rtl/vis_bank_reader.sv | 188 ++++++++++++++++++
 tb/tb_vis_bank_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tart_pkg.sv
// Shared definitions for the correlator visibilities readout path.
package tart_pkg;

    localparam int ACCUM_DEF = 36;
    localparam int CORES_DEF = 18;
    localparam int WORDS_DEF = 32;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/vis_row_mux.sv
// Holds one fetched SRAM row and presents one accumulator at a time, core 0 first.
module vis_row_mux
    import tart_pkg::*;
#(
    parameter int ACCUM = ACCUM_DEF,
    parameter int CORES = CORES_DEF
) (
    input  logic                     clock,
    input  logic                     reset_ni,
    input  logic                     load_i,
    input  logic                     advance_i,
    input  logic [CORES*ACCUM-1:0]   row_i,
    output logic [ACCUM-1:0]         data_o
);

    logic [CORES*ACCUM-1:0] row_q;
    logic [CORES*ACCUM-1:0] row_d;

    // Advancing shifts the next core into the low slot, so the select is always slot 0.
    always_comb begin
        row_d = row_q;
        if (load_i) begin
            row_d = row_i;
        end else if (advance_i) begin
            row_d = row_q >> ACCUM;
        end
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign data_o = row_q[ACCUM-1:0];

endmodule

// File: rtl/vis_bank_reader.sv
// Drains one visibilities bank row by row onto a valid/ready stream, then frees it.
// Optional per-bank header beat when READOUT_HEADER_EN is defined.
module vis_bank_reader
    import tart_pkg::*;
#(
    parameter int ACCUM = ACCUM_DEF,
    parameter int CORES = CORES_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int WBITS = 5,
    parameter int BBITS = 2,
    parameter int CBITS = 5
) (
    input  logic                     clock,
    input  logic                     reset_ni,
    input  logic                     bank_ready_i,
    input  logic [BBITS-1:0]         bank_index_i,
    output logic                     bank_free_o,
    output logic [BBITS-1:0]         bank_free_idx_o,
    output logic                     sram_ce_o,
    output logic [BBITS+WBITS-1:0]   sram_addr_o,
    input  logic [CORES*ACCUM-1:0]   sram_data_i,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [ACCUM-1:0]         m_tdata,
    output logic                     m_tlast,
    output logic                     busy_o,
    output logic                     overflow_o
);

    localparam logic [CBITS-1:0] CORE_LAST = CBITS'(CORES - 1);
    localparam logic [WBITS-1:0] ROW_LAST  = WBITS'(WORDS - 1);

`ifdef READOUT_HEADER_EN
    localparam state_e FIRST_ST = ST_HEADER;
`else
    localparam state_e FIRST_ST = ST_FETCH;
`endif

    state_e             state_q, state_d;
    logic [BBITS-1:0]   bank_q, bank_d;
    logic [BBITS-1:0]   pend_idx_q, pend_idx_d;
    logic               pend_valid_q, pend_valid_d;
    logic [WBITS-1:0]   row_q, row_d;
    logic [CBITS-1:0]   core_q, core_d;
    logic               overflow_q, overflow_d;
    logic               load, advance, strobe_taken;
    logic [ACCUM-1:0]   row_word;

`ifdef READOUT_HEADER_EN
    logic [ACCUM-1:0]   hdr_word;
    assign hdr_word = ACCUM'({HDR_MAGIC, bank_q, 16'(CORES * WORDS)});
`endif

    vis_row_mux #(
        .ACCUM (ACCUM),
        .CORES (CORES)
    ) u_row_mux (
        .clock     (clock),
        .reset_ni  (reset_ni),
        .load_i    (load),
        .advance_i (advance),
        .row_i     (sram_data_i),
        .data_o    (row_word)
    );

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            bank_q       <= '0;
            pend_idx_q   <= '0;
            pend_valid_q <= 1'b0;
            row_q        <= '0;
            core_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            pend_idx_q   <= pend_idx_d;
            pend_valid_q <= pend_valid_d;
            row_q        <= row_d;
            core_q       <= core_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bank_d          = bank_q;
        pend_idx_d      = pend_idx_q;
        pend_valid_d    = pend_valid_q;
        row_d           = row_q;
        core_d          = core_q;
        overflow_d      = overflow_q;
        load            = 1'b0;
        advance         = 1'b0;
        strobe_taken    = 1'b0;
        bank_free_o     = 1'b0;
        bank_free_idx_o = '0;
        sram_ce_o       = 1'b0;
        sram_addr_o     = '0;
        m_tvalid        = 1'b0;
        m_tdata         = '0;
        m_tlast         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bank_ready_i) begin
                    strobe_taken = 1'b1;
                    bank_d       = bank_index_i;
                    row_d        = '0;
                    core_d       = '0;
                    state_d      = FIRST_ST;
                end
            end
`ifdef READOUT_HEADER_EN
            ST_HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = hdr_word;
                if (m_tready) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FETCH: begin
                sram_ce_o   = 1'b1;
                sram_addr_o = {bank_q, row_q};
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                load    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                m_tvalid = 1'b1;
                m_tdata  = row_word;
                m_tlast  = (core_q == CORE_LAST) && (row_q == ROW_LAST);
                if (m_tready) begin
                    advance = 1'b1;
                    if (core_q == CORE_LAST) begin
                        core_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d   = row_q + WBITS'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        core_d = core_q + CBITS'(1);
                    end
                end
            end
            ST_DONE: begin
                bank_free_o     = 1'b1;
                bank_free_idx_o = bank_q;
                row_d           = '0;
                core_d          = '0;
                if (pend_valid_q) begin
                    bank_d       = pend_idx_q;
                    pend_valid_d = 1'b0;
                    state_d      = FIRST_ST;
                end else if (bank_ready_i) begin
                    // Freeing with nothing queued: a coincident strobe starts straight away.
                    strobe_taken = 1'b1;
                    bank_d       = bank_index_i;
                    state_d      = FIRST_ST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bank_ready_i && !strobe_taken) begin
            if (pend_valid_q) begin
                overflow_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_idx_d   = bank_index_i;
            end
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_vis_bank_reader.sv
// Directed bench for vis_bank_reader: ordering, backpressure, pending/overflow, reset, header option.
module tb_vis_bank_reader;

    localparam int ACCUM = 36;
    localparam int CORES = 18;
    localparam int WORDS = 32;
    localparam int BEATS = CORES * WORDS;

    logic                   clock = 1'b0;
    logic                   reset_ni = 1'b0;
    logic                   bank_ready_i = 1'b0;
    logic [1:0]             bank_index_i = 2'd0;
    logic                   bank_free_o;
    logic [1:0]             bank_free_idx_o;
    logic                   sram_ce_o;
    logic [6:0]             sram_addr_o;
    logic [CORES*ACCUM-1:0] sram_data_i = '0;
    logic                   m_tvalid;
    logic                   m_tready = 1'b1;
    logic [ACCUM-1:0]       m_tdata;
    logic                   m_tlast;
    logic                   busy_o;
    logic                   overflow_o;

    int n_err = 0;
    int n_chk = 0;
    int free_cnt = 0;

    vis_bank_reader dut (
        .clock           (clock),
        .reset_ni        (reset_ni),
        .bank_ready_i    (bank_ready_i),
        .bank_index_i    (bank_index_i),
        .bank_free_o     (bank_free_o),
        .bank_free_idx_o (bank_free_idx_o),
        .sram_ce_o       (sram_ce_o),
        .sram_addr_o     (sram_addr_o),
        .sram_data_i     (sram_data_i),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tdata         (m_tdata),
        .m_tlast         (m_tlast),
        .busy_o          (busy_o),
        .overflow_o      (overflow_o)
    );

    always #5 clock = ~clock;

    // SRAM model: row data one cycle after ce, accumulator c of row w in bank b = {b,w,c}.
    always @(posedge clock) begin
        if (sram_ce_o) begin
            for (int c = 0; c < CORES; c++) begin
                sram_data_i[c*ACCUM +: ACCUM] <= ACCUM'((int'(sram_addr_o[6:5]) << 16) |
                                                       (int'(sram_addr_o[4:0]) << 8) | c);
            end
        end
    end

    always @(posedge clock) begin
        if (bank_free_o) free_cnt++;
    end

    function automatic logic [63:0] exp_word(input int b, input int idx);
        return 64'((b << 16) | ((idx / CORES) << 8) | (idx % CORES));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at the negedge where the strobe (or pending-bank DONE) is presented.
    task automatic wait_first(input int b, input string tag);
        int lat;
        m_tready = 1'b1;
`ifdef READOUT_HEADER_EN
        lat = 0;
        do begin
            @(negedge clock);
            bank_ready_i = 1'b0;
            lat++;
        end while (!m_tvalid && lat < 20);
        check({tag, "_hdr_lat"}, 64'(lat), 64'd1);
        check({tag, "_hdr_data"}, 64'(m_tdata), 64'((32'hA5 << 18) | (b << 16) | BEATS));
        check({tag, "_hdr_last"}, 64'(m_tlast), 64'd0);
`endif
        @(negedge clock);
        bank_ready_i = 1'b0;
        lat = 1;
        check({tag, "_ce"}, 64'(sram_ce_o), 64'd1);
        check({tag, "_addr"}, 64'(sram_addr_o), 64'(b * 32));
        while (!m_tvalid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd3);
    endtask

    // Stream beats of bank b starting at the current negedge; optional strobes at cycles i1c/i2c.
    task automatic drain(input int b, input bit rnd, input int stop,
                         input int i1c, input int i1b, input int i2c, input int i2b,
                         input string tag);
        int idx = 0;
        int cyc = 0;
        bit hold = 1'b0;
        bit r;
        logic [ACCUM-1:0] hd;
        logic hl;
        while (idx < stop && cyc < 5000) begin
            if (hold) begin
                check({tag, "_hold_valid"}, 64'(m_tvalid), 64'd1);
                check({tag, "_hold_data"}, 64'(m_tdata), 64'(hd));
                check({tag, "_hold_last"}, 64'(m_tlast), 64'(hl));
            end
            bank_ready_i = (cyc == i1c) || (cyc == i2c);
            bank_index_i = (cyc == i2c) ? 2'(i2b) : 2'(i1b);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready = r;
            if (m_tvalid) begin
                check({tag, "_data"}, 64'(m_tdata), exp_word(b, idx));
                check({tag, "_last"}, 64'(m_tlast), 64'(idx == BEATS - 1));
                if (r) begin
                    idx++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    hd = m_tdata;
                    hl = m_tlast;
                end
            end else begin
                hold = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        bank_ready_i = 1'b0;
        m_tready = 1'b1;
        check({tag, "_beats"}, 64'(idx), 64'(stop));
        $display("bank %0d %s: %0d beats in %0d cycles", b, tag, idx, cyc);
    endtask

    task automatic finish_bank(input int b, input string tag);
        check({tag, "_free"}, 64'(bank_free_o), 64'd1);
        check({tag, "_free_idx"}, 64'(bank_free_idx_o), 64'(b));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_valid", 64'(m_tvalid), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ce", 64'(sram_ce_o), 64'd0);
        check("rst_free", 64'(bank_free_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        reset_ni = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_busy", 64'(busy_o), 64'd0);

        // Single bank, ready always high
        bank_ready_i = 1'b1;
        bank_index_i = 2'd1;
        wait_first(1, "s1");
        drain(1, 1'b0, BEATS, -1, 0, -1, 0, "s1");
        finish_bank(1, "s1");
        @(negedge clock);
        check("s1_free_pulse", 64'(bank_free_o), 64'd0);
        check("s1_idle", 64'(busy_o), 64'd0);
        check("s1_free_cnt", 64'(free_cnt), 64'd1);

        // Random backpressure
        bank_ready_i = 1'b1;
        bank_index_i = 2'd0;
        wait_first(0, "s2");
        drain(0, 1'b1, BEATS, -1, 0, -1, 0, "s2");
        finish_bank(0, "s2");
        @(negedge clock);
        check("s2_idle", 64'(busy_o), 64'd0);

        // Pending bank 2, then overflow with bank 3
        bank_ready_i = 1'b1;
        bank_index_i = 2'd1;
        wait_first(1, "s3a");
        check("s3_ovf_before", 64'(overflow_o), 64'd0);
        drain(1, 1'b0, BEATS, 40, 2, 200, 3, "s3a");
        finish_bank(1, "s3a");
        check("s3_ovf_set", 64'(overflow_o), 64'd1);
        wait_first(2, "s3b");
        drain(2, 1'b0, BEATS, -1, 0, -1, 0, "s3b");
        finish_bank(2, "s3b");
        @(negedge clock);
        check("s3_no_bank3", 64'(busy_o), 64'd0);
        repeat (4) @(negedge clock);
        check("s3_no_bank3_valid", 64'(m_tvalid), 64'd0);
        check("s3_ovf_sticky", 64'(overflow_o), 64'd1);

        // Reset in the middle of row 7, core 4
        bank_ready_i = 1'b1;
        bank_index_i = 2'd0;
        wait_first(0, "s4");
        drain(0, 1'b0, 7 * CORES + 4, -1, 0, -1, 0, "s4");
        check("s4_at_r7c4", 64'(m_tdata), exp_word(0, 7 * CORES + 4));
        reset_ni = 1'b0;
        #1;
        check("s4_rst_valid", 64'(m_tvalid), 64'd0);
        check("s4_rst_data", 64'(m_tdata), 64'd0);
        check("s4_rst_busy", 64'(busy_o), 64'd0);
        check("s4_rst_ovf", 64'(overflow_o), 64'd0);
        check("s4_rst_ce", 64'(sram_ce_o), 64'd0);
        @(negedge clock);
        reset_ni = 1'b1;
        @(negedge clock);
        check("s4_post_idle", 64'(busy_o), 64'd0);
        bank_ready_i = 1'b1;
        bank_index_i = 2'd2;
        wait_first(2, "s4r");
        drain(2, 1'b0, BEATS, -1, 0, -1, 0, "s4r");
        finish_bank(2, "s4r");

        // Strobe in the DONE-exit cycle
        @(negedge clock);
        bank_ready_i = 1'b1;
        bank_index_i = 2'd1;
        wait_first(1, "s5a");
        drain(1, 1'b0, BEATS, -1, 0, -1, 0, "s5a");
        finish_bank(1, "s5a");
        bank_ready_i = 1'b1;
        bank_index_i = 2'd3;
        wait_first(3, "s5b");
        check("s5_ovf", 64'(overflow_o), 64'd0);
        drain(3, 1'b0, BEATS, -1, 0, -1, 0, "s5b");
        finish_bank(3, "s5b");
        @(negedge clock);
        check("s5_idle", 64'(busy_o), 64'd0);
        check("s5_ovf_end", 64'(overflow_o), 64'd0);
        check("total_frees", 64'(free_cnt), 64'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
